if_fetch_unit: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline, the initiator side of the Instruc_Mem read interface.
- Owns the PC and presents byte addresses to Instruc_Mem, which has a synchronous read with 1-cycle latency.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall from hazard detection, branch/jump redirect with flush of the in-flight fetch, and a skid hold so stalled data is not lost.

---
 rtl/if_pkg.sv | 20 ++
 rtl/fetch_hold_buf.sv | 29 ++
 rtl/if_fetch_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared IF-stage definitions: fetch constants and the IF/ID pipeline register layout.
package if_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc4;
    logic               valid;
  } if_id_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid register: keeps the instruction returned during a stall,
// because the memory output moves on to the next address while IF/ID is frozen.
module fetch_hold_buf
  import if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic               clear,
  input  logic [INSTR_W-1:0] data_in,
  output logic [INSTR_W-1:0] data_src,
  output logic               held_valid
);
  logic [INSTR_W-1:0] held_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_data  <= '0;
      held_valid <= 1'b0;
    end else if (clear) begin
      held_valid <= 1'b0;
    end else if (capture && !held_valid) begin
      held_data  <= data_in;
      held_valid <= 1'b1;
    end
  end

  assign data_src = held_valid ? held_data : data_in;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, tracks the in-flight Instruc_Mem read
// and loads the IF/ID register, with stall, redirect/flush and skid hold.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = if_pkg::RESET_PC,
  parameter logic [31:0] PC_INC    = if_pkg::PC_INC,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic [31:0] fetch_count_o
);
  import if_pkg::*;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               req_valid;
  if_id_t             if_id;
  logic [31:0]        fetch_count;
  logic [INSTR_W-1:0] data_src;
  logic               held_valid;
  logic               hold_capture;
  logic               hold_clear;

  // Capture only while truly stalled; any redirect or advance empties the buffer.
  assign hold_capture = stall_i && !redirect_i && req_valid;
  assign hold_clear   = redirect_i || !stall_i;

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst        (rst),
    .capture    (hold_capture),
    .clear      (hold_clear),
    .data_in    (imem_data_i),
    .data_src   (data_src),
    .held_valid (held_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      req_valid   <= 1'b0;
      if_id.instr <= NOP_INSTR;
      if_id.pc    <= '0;
      if_id.pc4   <= '0;
      if_id.valid <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_i) begin
      pc          <= word_align(redirect_pc_i);
      req_valid   <= 1'b0;
      if_id.instr <= NOP_INSTR;
      if_id.valid <= 1'b0;
    end else if (!stall_i) begin
      if_id.instr <= req_valid ? data_src : NOP_INSTR;
      if_id.pc    <= req_pc;
      if_id.pc4   <= req_pc + 32'd4;
      if_id.valid <= req_valid;
      req_pc      <= pc;
      req_valid   <= 1'b1;
      pc          <= pc + PC_INC;
      fetch_count <= fetch_count + {31'd0, req_valid};
    end
  end

  assign imem_addr_o   = word_align(pc);
  assign if_id_instr_o = if_id.instr;
  assign if_id_pc_o    = if_id.pc;
  assign if_id_pc4_o   = if_id.pc4;
  assign if_id_valid_o = if_id.valid;
  assign fetch_count_o = fetch_count;
endmodule
